// File: rtl/sram_vga_pkg.sv
// Shared constants, types and helpers for the SRAM frame-buffer VGA engine.
package sram_vga_pkg;

  localparam int unsigned PIX_RGB565 = 0;
  localparam int unsigned PIX_GRAY8  = 1;

  localparam int unsigned VGA_H_ACTIVE = 640;
  localparam int unsigned VGA_H_FP     = 16;
  localparam int unsigned VGA_H_SYNC   = 96;
  localparam int unsigned VGA_H_BP     = 48;
  localparam int unsigned VGA_V_ACTIVE = 480;
  localparam int unsigned VGA_V_FP     = 10;
  localparam int unsigned VGA_V_SYNC   = 2;
  localparam int unsigned VGA_V_BP     = 33;

  typedef enum logic [1:0] {
    SLOT_HOST_IDLE,
    SLOT_DISPLAY,
    SLOT_HOST_READ,
    SLOT_HOST_WRITE
  } slot_e;

  function automatic int unsigned line_total(input int unsigned active, input int unsigned fp,
                                             input int unsigned sync, input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

  function automatic int unsigned frame_words(input int unsigned h_active, input int unsigned v_active);
    return h_active * v_active;
  endfunction

  function automatic logic [23:0] format_pixel(input logic [15:0] d, input int unsigned fmt);
    if (fmt == PIX_GRAY8) return {d[15:8], d[15:8], d[15:8]};
    return {d[15:11], d[15:13], d[10:5], d[10:9], d[4:0], d[4:2]};
  endfunction

endpackage

// File: rtl/sram_vga_frame_reader_timing.sv
// VGA timing: pixel phase, h/v counters, raw sync and active-area flags.
module vga_timing_gen
  import sram_vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
  parameter int unsigned H_FP     = VGA_H_FP,
  parameter int unsigned H_SYNC   = VGA_H_SYNC,
  parameter int unsigned H_BP     = VGA_H_BP,
  parameter int unsigned V_ACTIVE = VGA_V_ACTIVE,
  parameter int unsigned V_FP     = VGA_V_FP,
  parameter int unsigned V_SYNC   = VGA_V_SYNC,
  parameter int unsigned V_BP     = VGA_V_BP
) (
  input  logic clk,
  input  logic rst_n,
  output logic phase,
  output logic active,
  output logic hsync,
  output logic vsync,
  output logic vs_start
);

  localparam int unsigned H_TOTAL = line_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned V_TOTAL = line_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int unsigned H_W = $clog2(H_TOTAL + 1);
  localparam int unsigned V_W = $clog2(V_TOTAL + 1);

  localparam logic [H_W-1:0] H_LAST   = H_W'(H_TOTAL - 1);
  localparam logic [H_W-1:0] H_ACT    = H_W'(H_ACTIVE);
  localparam logic [H_W-1:0] HS_START = H_W'(H_ACTIVE + H_FP);
  localparam logic [H_W-1:0] HS_END   = H_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [V_W-1:0] V_LAST   = V_W'(V_TOTAL - 1);
  localparam logic [V_W-1:0] V_ACT    = V_W'(V_ACTIVE);
  localparam logic [V_W-1:0] VS_START = V_W'(V_ACTIVE + V_FP);
  localparam logic [V_W-1:0] VS_END   = V_W'(V_ACTIVE + V_FP + V_SYNC);

  logic [H_W-1:0] h_cnt;
  logic [V_W-1:0] v_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase <= 1'b0;
      h_cnt <= '0;
      v_cnt <= '0;
    end else begin
      phase <= ~phase;
      if (phase) begin
        if (h_cnt == H_LAST) begin
          h_cnt <= '0;
          v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
        end else begin
          h_cnt <= h_cnt + 1'b1;
        end
      end
    end
  end

  always_comb begin
    active   = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    hsync    = !((h_cnt >= HS_START) && (h_cnt < HS_END));
    vsync    = !((v_cnt >= VS_START) && (v_cnt < VS_END));
    vs_start = !phase && (h_cnt == '0) && (v_cnt == VS_START);
  end

endmodule

// File: rtl/sram_vga_frame_reader.sv
// SRAM frame-buffer scan-out with a shared req/ack host port on the same SRAM.
module sram_vga_frame_reader
  import sram_vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE   = VGA_H_ACTIVE,
  parameter int unsigned H_FP       = VGA_H_FP,
  parameter int unsigned H_SYNC     = VGA_H_SYNC,
  parameter int unsigned H_BP       = VGA_H_BP,
  parameter int unsigned V_ACTIVE   = VGA_V_ACTIVE,
  parameter int unsigned V_FP       = VGA_V_FP,
  parameter int unsigned V_SYNC     = VGA_V_SYNC,
  parameter int unsigned V_BP       = VGA_V_BP,
  parameter int unsigned ADDR_W     = 20,
  parameter int unsigned NUM_FRAMES = 3,
  parameter int unsigned PIX_FMT    = PIX_RGB565
) (
  input  logic              CLOCK_50,
  input  logic              RESET_N,
  input  logic              DISP_EN,
  input  logic [1:0]        FRAME_SEL,
  input  logic              HOST_REQ,
  input  logic              HOST_WE,
  input  logic [ADDR_W-1:0] HOST_ADDR,
  input  logic [15:0]       HOST_WDATA,
  output logic [15:0]       HOST_RDATA,
  output logic              HOST_ACK,
  output logic [ADDR_W-1:0] SRAM_ADDR,
  inout  wire  [15:0]       SRAM_DQ,
  output logic              SRAM_CE_N,
  output logic              SRAM_OE_N,
  output logic              SRAM_WE_N,
  output logic              SRAM_UB_N,
  output logic              SRAM_LB_N,
  output logic [7:0]        VGA_R,
  output logic [7:0]        VGA_G,
  output logic [7:0]        VGA_B,
  output logic              VGA_CLK,
  output logic              VGA_HS,
  output logic              VGA_VS,
  output logic              VGA_BLANK_N,
  output logic              VGA_SYNC_N
);

  localparam int unsigned FRAME_WORDS = frame_words(H_ACTIVE, V_ACTIVE);

  logic phase, active, hsync_raw, vsync_raw, vs_start;

  vga_timing_gen #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_timing (
    .clk      (CLOCK_50),
    .rst_n    (RESET_N),
    .phase    (phase),
    .active   (active),
    .hsync    (hsync_raw),
    .vsync    (vsync_raw),
    .vs_start (vs_start)
  );

  slot_e             slot;
  logic              vis_raw;
  logic              host_go;
  logic              write_drive;
  logic [ADDR_W-1:0] frame_base, next_base, pix_ptr;

  // A held request is blocked in its own ACK cycle so it counts as a new one.
  always_comb begin
    vis_raw = active && DISP_EN;
    slot    = SLOT_HOST_IDLE;
    host_go = 1'b0;
    if (!phase && vis_raw) begin
      slot = SLOT_DISPLAY;
    end else if (HOST_REQ && !HOST_ACK) begin
      host_go = 1'b1;
      slot    = HOST_WE ? SLOT_HOST_WRITE : SLOT_HOST_READ;
    end
  end

  always_comb begin
    next_base = frame_base;
    if (32'(FRAME_SEL) < NUM_FRAMES) next_base = ADDR_W'(32'(FRAME_SEL) * FRAME_WORDS);
  end

  // Pointer advances on every active pixel so it stays correct across DISP_EN gaps.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      frame_base <= '0;
      pix_ptr    <= '0;
    end else if (vs_start) begin
      frame_base <= next_base;
      pix_ptr    <= next_base;
    end else if (!phase && active) begin
      pix_ptr <= pix_ptr + 1'b1;
    end
  end

  // Reset gates the write strobe directly so a write in flight is cut off at once.
  always_comb begin
    write_drive = (slot == SLOT_HOST_WRITE) && RESET_N;
    SRAM_ADDR   = (slot == SLOT_DISPLAY) ? pix_ptr : HOST_ADDR;
    SRAM_WE_N   = !write_drive;
    SRAM_OE_N   = write_drive;
    SRAM_CE_N   = 1'b0;
    SRAM_UB_N   = 1'b0;
    SRAM_LB_N   = 1'b0;
    VGA_SYNC_N  = 1'b0;
    VGA_CLK     = phase;
  end

  assign SRAM_DQ = write_drive ? HOST_WDATA : {16{1'bz}};

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      HOST_ACK   <= 1'b0;
      HOST_RDATA <= '0;
    end else begin
      HOST_ACK <= host_go;
      if (slot == SLOT_HOST_READ) HOST_RDATA <= SRAM_DQ;
    end
  end

  logic [15:0] pix_word;
  logic        vis_d1, hs_d1, vs_d1;

  // RGB refreshes only in phase=1, one cycle after the word lands, matching the 2-cycle sync delay.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      pix_word    <= '0;
      vis_d1      <= 1'b0;
      hs_d1       <= 1'b1;
      vs_d1       <= 1'b1;
      VGA_HS      <= 1'b1;
      VGA_VS      <= 1'b1;
      VGA_BLANK_N <= 1'b0;
      VGA_R       <= '0;
      VGA_G       <= '0;
      VGA_B       <= '0;
    end else begin
      if (slot == SLOT_DISPLAY) pix_word <= SRAM_DQ;
      vis_d1      <= vis_raw;
      hs_d1       <= hsync_raw;
      vs_d1       <= vsync_raw;
      VGA_HS      <= hs_d1;
      VGA_VS      <= vs_d1;
      VGA_BLANK_N <= vis_d1;
      if (phase) begin
        {VGA_R, VGA_G, VGA_B} <= vis_d1 ? format_pixel(pix_word, PIX_FMT) : '0;
      end
    end
  end

endmodule

// File: tb/tb_sram_vga_frame_reader.sv
// Directed bench for sram_vga_frame_reader using a small 16x10 raster and an SRAM model.
module tb_sram_vga_frame_reader;

  localparam int unsigned HT = 16;
  localparam int unsigned VT = 10;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, disp_en, host_req, host_we, preload;
  logic [1:0]  frame_sel;
  logic [19:0] host_addr;
  logic [15:0] host_wdata;
  logic [15:0] host_rdata;
  logic        host_ack;
  wire  [15:0] sram_dq;
  logic [19:0] sram_addr;
  logic        ce_n, oe_n, we_n, ub_n, lb_n;
  logic [7:0]  r, g, b;
  logic        vga_clk, hs, vs, blank_n, sync_n;

  sram_vga_frame_reader #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .ADDR_W(20), .NUM_FRAMES(3), .PIX_FMT(0)
  ) dut (
    .CLOCK_50(clk), .RESET_N(rst_n), .DISP_EN(disp_en), .FRAME_SEL(frame_sel),
    .HOST_REQ(host_req), .HOST_WE(host_we), .HOST_ADDR(host_addr), .HOST_WDATA(host_wdata),
    .HOST_RDATA(host_rdata), .HOST_ACK(host_ack), .SRAM_ADDR(sram_addr), .SRAM_DQ(sram_dq),
    .SRAM_CE_N(ce_n), .SRAM_OE_N(oe_n), .SRAM_WE_N(we_n), .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n),
    .VGA_R(r), .VGA_G(g), .VGA_B(b), .VGA_CLK(vga_clk), .VGA_HS(hs), .VGA_VS(vs),
    .VGA_BLANK_N(blank_n), .VGA_SYNC_N(sync_n)
  );

  logic [15:0] g_rdata;
  logic        g_ack;
  wire  [15:0] g_dq;
  logic [19:0] g_addr;
  logic        g_ce_n, g_oe_n, g_we_n, g_ub_n, g_lb_n;
  logic [7:0]  g_r, g_g, g_b;
  logic        g_clk, g_hs, g_vs, g_blank_n, g_sync_n;

  sram_vga_frame_reader #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .ADDR_W(20), .NUM_FRAMES(3), .PIX_FMT(1)
  ) dut_gray (
    .CLOCK_50(clk), .RESET_N(rst_n), .DISP_EN(1'b1), .FRAME_SEL(2'd0),
    .HOST_REQ(1'b0), .HOST_WE(1'b0), .HOST_ADDR(20'h0), .HOST_WDATA(16'h0),
    .HOST_RDATA(g_rdata), .HOST_ACK(g_ack), .SRAM_ADDR(g_addr), .SRAM_DQ(g_dq),
    .SRAM_CE_N(g_ce_n), .SRAM_OE_N(g_oe_n), .SRAM_WE_N(g_we_n), .SRAM_UB_N(g_ub_n), .SRAM_LB_N(g_lb_n),
    .VGA_R(g_r), .VGA_G(g_g), .VGA_B(g_b), .VGA_CLK(g_clk), .VGA_HS(g_hs), .VGA_VS(g_vs),
    .VGA_BLANK_N(g_blank_n), .VGA_SYNC_N(g_sync_n)
  );

  // Asynchronous SRAM model shared by both instances (the gray one only reads).
  logic [15:0] mem [0:(1<<20)-1];

  function automatic logic [15:0] init_word(input int a);
    if (a == 0) return 16'h7F3C;
    if (a == 49) return 16'hF81F;
    return 16'h8000 | 16'(a);
  endfunction

  function automatic logic [23:0] rgb565(input logic [15:0] w);
    return {w[15:11], w[15:13], w[10:5], w[10:9], w[4:0], w[4:2]};
  endfunction

  assign sram_dq = (!oe_n && we_n) ? mem[sram_addr] : 16'hzzzz;
  assign g_dq    = (!g_oe_n && g_we_n) ? mem[g_addr] : 16'hzzzz;

  always @(posedge clk) begin
    if (preload) begin
      for (int a = 0; a < 256; a++) mem[a] <= init_word(a);
    end else if (!we_n) begin
      mem[sram_addr] <= sram_dq;
    end
  end

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Output monitor: sync periods/widths and per-frame pixel captures keyed by VS fall count.
  int unsigned cyc = 0, hs_fall_cyc = 0, hs_period = 0, hs_low = 0;
  int unsigned vs_fall_cyc = 0, vs_period = 0, vs_low = 0, bl_start = 0, bl_high = 0;
  int unsigned vs_falls = 0, act_idx = 0, sum = 0;
  logic        hs_prev = 1'b1, vs_prev = 1'b1, bl_prev = 1'b0;
  logic [23:0] cur_first = '0, cur_second = '0, last_rgb = '0;
  logic [23:0] first_at [16];
  logic [23:0] second_at [16];
  logic [23:0] last_at [16];
  int unsigned sum_at [16];
  logic        g_seen = 1'b0;
  logic [23:0] g_first = '0;

  always @(negedge clk) begin
    cyc++;
    if (hs_prev && !hs) begin hs_period = cyc - hs_fall_cyc; hs_fall_cyc = cyc; end
    if (!hs_prev && hs) hs_low = cyc - hs_fall_cyc;
    if (vs_prev && !vs) begin
      vs_period = cyc - vs_fall_cyc;
      vs_fall_cyc = cyc;
      vs_falls++;
      if (vs_falls < 16) begin
        first_at[vs_falls]  = cur_first;
        second_at[vs_falls] = cur_second;
        last_at[vs_falls]   = last_rgb;
        sum_at[vs_falls]    = sum;
      end
      sum = 0;
      act_idx = 0;
    end
    if (!vs_prev && vs) vs_low = cyc - vs_fall_cyc;
    if (!bl_prev && blank_n) bl_start = cyc;
    if (bl_prev && !blank_n) bl_high = cyc - bl_start;
    if (blank_n) begin
      if (act_idx == 0) cur_first = {r, g, b};
      if (act_idx == 2) cur_second = {r, g, b};
      act_idx++;
      last_rgb = {r, g, b};
      sum = sum * 33 + 32'({r, g, b});
    end
    if (g_blank_n && !g_seen) begin g_first = {g_r, g_g, g_b}; g_seen = 1'b1; end
    hs_prev = hs;
    vs_prev = vs;
    bl_prev = blank_n;
  end

  task automatic wait_vs(input int unsigned n);
    int unsigned t = 0;
    while (vs_falls < n && t < 2000) begin @(negedge clk); t++; end
    if (vs_falls < n) check("vs_wait", vs_falls, n);
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_blank_high();
    int unsigned t = 0;
    while (!blank_n && t < 2000) begin @(negedge clk); t++; end
    if (!blank_n) check("blank_wait", 32'(blank_n), 32'd1);
  endtask

  task automatic host_op(input logic we, input logic [19:0] a, input logic [15:0] d,
                         output logic [15:0] rd, output int unsigned lat);
    @(posedge clk); #1;
    host_req = 1'b1; host_we = we; host_addr = a; host_wdata = d;
    lat = 0;
    do begin @(posedge clk); #1; lat++; end while (!host_ack && lat < 8);
    rd = host_rdata;
    host_req = 1'b0;
  endtask

  logic [15:0] rd;
  int unsigned lat, acks, consec;
  logic        prev_ack;
  int unsigned t;

  initial begin
    rst_n = 1'b0; disp_en = 1'b1; frame_sel = 2'd1; preload = 1'b1;
    host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
    repeat (3) @(negedge clk);
    preload = 1'b0;
    check("rst_hs", 32'(hs), 32'd1);
    check("rst_vs", 32'(vs), 32'd1);
    check("rst_blank", 32'(blank_n), 32'd0);
    check("rst_rgb", 32'({r, g, b}), 32'd0);
    check("rst_ack", 32'(host_ack), 32'd0);
    check("rst_rdata", 32'(host_rdata), 32'd0);
    check("rst_we_n", 32'(we_n), 32'd1);
    check("rst_vga_clk", 32'(vga_clk), 32'd0);
    check("rst_sram_addr", 32'(sram_addr), 32'd0);
    check("rst_dq_released", 32'(sram_dq), 32'h7F3C);
    rst_n = 1'b1;

    wait_vs(2);
    check("hs_period", hs_period, 2 * HT);
    check("hs_low", hs_low, 6);
    check("vs_period", vs_period, 2 * HT * VT);
    check("vs_low", vs_low, 2 * HT * 2);
    check("blank_high", bl_high, 16);
    check("f0_first_pix", 32'(first_at[1]), 32'(rgb565(16'h7F3C)));
    check("f1_first_pix", 32'(first_at[2]), 32'(rgb565(16'h8030)));
    check("f1_f81f_pix", 32'(second_at[2]), 32'h00FF00FF);
    check("f1_last_pix", 32'(last_at[2]), 32'(rgb565(16'h805F)));
    check("gray_7f", 32'(g_first), 32'h007F7F7F);

    wait_blank_high();
    frame_sel = 2'd2;
    host_op(1'b1, 20'h12345, 16'hA5A5, rd, lat);
    check("wr_lat_le2", 32'(lat >= 1 && lat <= 2), 32'd1);
    host_op(1'b0, 20'h12345, 16'h0000, rd, lat);
    check("rd_lat_le2", 32'(lat >= 1 && lat <= 2), 32'd1);
    check("rd_data", 32'(rd), 32'h0000A5A5);
    wait_vs(3);
    check("midframe_sel_last", 32'(last_at[3]), 32'(rgb565(16'h805F)));
    check("stream_unchanged", sum_at[3], sum_at[2]);

    wait_blank_high();
    frame_sel = 2'd3;
    wait_vs(4);
    check("f2_first_pix", 32'(first_at[4]), 32'(rgb565(16'h8060)));
    wait_vs(5);
    check("sel3_ignored", 32'(first_at[5]), 32'(rgb565(16'h8060)));

    wait_blank_high();
    @(posedge clk); #1;
    disp_en = 1'b0;
    repeat (4) @(negedge clk);
    check("dis_blank", 32'(blank_n), 32'd0);
    check("dis_rgb", 32'({r, g, b}), 32'd0);
    host_op(1'b0, 20'h12345, 16'h0000, rd, lat);
    check("dis_rd_lat", lat, 1);
    check("dis_rd_data", 32'(rd), 32'h0000A5A5);

    @(posedge clk); #1;
    host_req = 1'b1; host_we = 1'b1; host_addr = 20'h00100; host_wdata = 16'h0BB0;
    acks = 0; consec = 0; prev_ack = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (host_ack) acks++;
      if (host_ack && prev_ack) consec++;
      prev_ack = host_ack;
    end
    host_req = 1'b0;
    check("b2b_acks", acks, 4);
    check("b2b_consec", consec, 0);

    disp_en = 1'b1;
    t = 0;
    while (vs && t < 2000) begin @(negedge clk); t++; end
    host_op(1'b0, 20'h12345, 16'h0000, rd, lat);
    check("vblank_rd_lat", lat, 1);
    check("vblank_rd_data", 32'(rd), 32'h0000A5A5);

    disp_en = 1'b0;
    @(posedge clk); #1;
    host_req = 1'b1; host_we = 1'b1; host_addr = 20'h00080; host_wdata = 16'h1234;
    #1;
    check("wr_we_n_low", 32'(we_n), 32'd0);
    check("wr_dq_driven", 32'(sram_dq), 32'h00001234);
    rst_n = 1'b0;
    #1;
    check("rstw_we_n", 32'(we_n), 32'd1);
    check("rstw_oe_n", 32'(oe_n), 32'd0);
    check("rstw_dq", 32'(sram_dq), 32'h00008080);
    check("rstw_ack", 32'(host_ack), 32'd0);
    host_req = 1'b0;
    @(negedge clk);
    check("rstw_ack2", 32'(host_ack), 32'd0);
    check("rstw_hs", 32'(hs), 32'd1);
    check("rstw_vs", 32'(vs), 32'd1);
    check("rstw_blank", 32'(blank_n), 32'd0);
    check("rstw_rgb", 32'({r, g, b}), 32'd0);
    check("rstw_rdata", 32'(host_rdata), 32'd0);
    @(posedge clk); #1;
    check("rstw_mem", 32'(mem[20'h00080]), 32'h00008080);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
